mem_loader: RTL and testbench

Bus initiator that writes a stream of words into the processor's RAM through the same MI/RI strobe interface the control unit uses. This is the writer side of program memory; the processor is the reader. The block holds the CPU while it runs, so programs and data can be loaded without a reset-time RAM image. It sits beside the control unit, and its strobes and write bus are OR/muxed onto the memory port while cpu_hold is high.

---
 rtl/mem_loader.sv | 130 +++++++++++++
 tb/tb_mem_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// Streams words into processor RAM over the MI/RI strobe port while holding the CPU.
// Each word costs an MI (address) cycle and an RI (data) cycle; MAR is parked at the end.
module mem_loader #(
   parameter int WIDTH     = 16,
   parameter int MAX_WORDS = 256,
   parameter int PARK_ADDR = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] start_addr,
   input  logic             abort,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             mem_mi,
   output logic             mem_ri,
   output logic [WIDTH-1:0] mem_write,
   output logic             cpu_hold,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic [WIDTH:0]   word_count
);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, PARK, FIN} state_t;

   localparam logic [WIDTH:0]   MAX_COUNT  = (WIDTH+1)'(MAX_WORDS);
   localparam logic [WIDTH-1:0] PARK_VALUE = WIDTH'(PARK_ADDR);

   state_t           state;
   logic [WIDTH-1:0] addr;
   logic             mi_q;
   logic             hold_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH:0]   count_next;

   assign count_next = word_count + (WIDTH+1)'(1);

   // abort masks the handshake so the word presented alongside it is never written
   assign in_ready = (state == DATA) && !abort;
   assign mem_ri   = in_ready && in_valid;
   assign mem_mi   = mi_q;
   assign cpu_hold = hold_q;
   assign busy     = busy_q;
   assign done     = done_q;

   always_comb begin
      mem_write = '0;
      case (state)
         ADDR:    mem_write = addr;
         DATA:    mem_write = in_data;
         PARK:    mem_write = PARK_VALUE;
         default: mem_write = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         addr       <= '0;
         word_count <= '0;
         overflow   <= 1'b0;
         mi_q       <= 1'b0;
         hold_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= ADDR;
                  addr       <= start_addr;
                  word_count <= '0;
                  overflow   <= 1'b0;
                  mi_q       <= 1'b1;
                  hold_q     <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            ADDR: begin
               if (abort) begin
                  state <= PARK;
               end else begin
                  state <= DATA;
                  mi_q  <= 1'b0;
               end
            end
            DATA: begin
               if (abort) begin
                  state <= PARK;
                  mi_q  <= 1'b1;
               end else if (in_valid) begin
                  addr       <= addr + WIDTH'(1);
                  word_count <= count_next;
                  mi_q       <= 1'b1;
                  if (in_last) begin
                     state <= PARK;
                  end else if (count_next == MAX_COUNT) begin
                     state    <= PARK;
                     overflow <= 1'b1;
                  end else begin
                     state <= ADDR;
                  end
               end
            end
            PARK: begin
               state  <= FIN;
               mi_q   <= 1'b0;
               hold_q <= 1'b0;
               done_q <= 1'b1;
            end
            FIN: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               mi_q   <= 1'b0;
               hold_q <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: a behavioural MAR/RAM model on the strobe port plus a write scoreboard,
// driven by a table of loads and hand-written abort and reset sequences.
module tb_mem_loader;

   localparam int WIDTH     = 8;
   localparam int MAX_WORDS = 4;

   logic       clk = 1'b0;
   logic       reset, start, abort, in_valid, in_last;
   logic [7:0] start_addr, in_data;
   logic       in_ready, mem_mi, mem_ri, cpu_hold, busy, done, overflow;
   logic [7:0] mem_write;
   logic [8:0] word_count;

   always #5 clk = ~clk;

   mem_loader #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS), .PARK_ADDR(0)) dut (
      .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .abort(abort),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .mem_mi(mem_mi), .mem_ri(mem_ri), .mem_write(mem_write), .cpu_hold(cpu_hold),
      .busy(busy), .done(done), .overflow(overflow), .word_count(word_count)
   );

   int errors = 0;
   int checks = 0;

   function automatic void check_output(input string name, input logic [31:0] actual,
                                        input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endfunction

   // Memory as the processor sees it: MAR loads on MI, RAM[MAR] written on RI
   bit [7:0] ram [256];
   bit [7:0] mar;
   always @(posedge clk) begin
      if (mem_ri) ram[mar] <= mem_write;
      if (mem_mi) mar <= mem_write;
   end

   typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
   wr_t exp_q[$];
   wr_t mon_e;
   int  mi_total = 0;

   always @(negedge clk) begin
      if (mem_mi) mi_total++;
      if (mem_mi && mem_ri) check_output("mi_ri_overlap", 32'd1, 32'd0);
      if (mem_ri) begin
         if (exp_q.size() == 0) begin
            check_output("sb_extra_write", {24'd0, mem_write}, 32'hFFFF_FFFF);
         end else begin
            mon_e = exp_q.pop_front();
            check_output("sb_addr", {24'd0, mar}, {24'd0, mon_e.a});
            check_output("sb_data", {24'd0, mem_write}, {24'd0, mon_e.d});
         end
      end
   end

   typedef struct {
      logic [7:0]      saddr;
      int              n;
      logic [0:5][7:0] data;
      int              last_idx;
      int              gap;
      int              exp_count;
      bit              exp_ovf;
   } vec_t;

   vec_t vecs [5];

   function automatic vec_t make_vec(input logic [7:0] sa, input int n, input logic [0:5][7:0] d,
                                     input int last_idx, input int gap, input int cnt, input bit ovf);
      vec_t v;
      v.saddr = sa; v.n = n; v.data = d; v.last_idx = last_idx;
      v.gap = gap; v.exp_count = cnt; v.exp_ovf = ovf;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one complete load; the stream holds in_valid high except for an optional gap before word 1
   task automatic apply_stimulus(input vec_t v);
      int k, cyc, gap_left, pushed, done_cycle, mi_start;
      logic [8:0] final_count;
      k = 0; cyc = 0; gap_left = v.gap; pushed = 0; done_cycle = -1;
      final_count = 9'(v.exp_count);
      mi_start = mi_total;
      start = 1'b1; start_addr = v.saddr; abort = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
      step();
      start = 1'b0;
      cyc = 1;
      while (done_cycle < 0 && cyc < 40) begin
         if (k < v.n && !(k == 1 && gap_left > 0)) begin
            in_valid = 1'b1;
            in_data  = v.data[k];
            in_last  = (k == v.last_idx);
            if (k < v.exp_count && k == pushed) begin
               exp_q.push_back('{a: v.saddr + 8'(k), d: v.data[k]});
               pushed++;
            end
         end else begin
            in_valid = 1'b0;
            in_last  = (gap_left > 0);
         end
         @(negedge clk);
         if (cyc == 1) begin
            check_output("start_clears_ovf", {31'd0, overflow}, 32'd0);
            check_output("addr_phase_mi", {31'd0, mem_mi}, 32'd1);
            check_output("addr_phase_hold", {31'd0, cpu_hold}, 32'd1);
            check_output("addr_phase_ready", {31'd0, in_ready}, 32'd0);
         end
         if (k == 1 && gap_left > 0 && in_ready) begin
            check_output("gap_no_ri", {31'd0, mem_ri}, 32'd0);
            check_output("gap_no_mi", {31'd0, mem_mi}, 32'd0);
            gap_left--;
         end
         if (k == v.exp_count && k < v.n) check_output("ready_after_max", {31'd0, in_ready}, 32'd0);
         if (done) begin
            done_cycle = cyc;
            check_output("done_count", {23'd0, word_count}, {23'd0, final_count});
            check_output("done_ovf", {31'd0, overflow}, {31'd0, v.exp_ovf});
            check_output("done_busy", {31'd0, busy}, 32'd1);
            check_output("done_hold", {31'd0, cpu_hold}, 32'd0);
         end else if (in_valid && in_ready) begin
            k++;
         end
         step();
         cyc++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
      check_output("done_latency", done_cycle, 2 * v.exp_count + 2 + v.gap);
      check_output("done_one_cycle", {31'd0, done}, 32'd0);
      check_output("idle_busy", {31'd0, busy}, 32'd0);
      check_output("count_holds", {23'd0, word_count}, {23'd0, final_count});
      check_output("mar_parked", {24'd0, mar}, 32'd0);
      check_output("mi_strobes", mi_total - mi_start, v.exp_count + 1);
      check_output("sb_pending", exp_q.size(), 0);
      for (int i = 0; i < v.exp_count; i++)
         check_output("ram_word", {24'd0, ram[v.saddr + 8'(i)]}, {24'd0, v.data[i]});
      step();
   endtask

   initial begin
      vecs[0] = make_vec(8'd100, 3, {8'h41, 8'h0B, 8'h4A, 24'h0}, 2, 0, 3, 1'b0);
      vecs[1] = make_vec(8'd100, 3, {8'h41, 8'h0B, 8'h4A, 24'h0}, 2, 3, 3, 1'b0);
      vecs[2] = make_vec(8'd10,  6, {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, -1, 0, 4, 1'b1);
      vecs[3] = make_vec(8'hFF,  2, {8'hC3, 8'h3C, 32'h0}, 1, 0, 2, 1'b0);
      vecs[4] = make_vec(8'd50,  4, {8'h01, 8'h02, 8'h03, 8'h04, 16'h0}, 3, 0, 4, 1'b0);

      reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      start_addr = 8'h00; in_data = 8'h00;
      repeat (2) @(negedge clk);
      check_output("rst_busy", {31'd0, busy}, 32'd0);
      check_output("rst_hold", {31'd0, cpu_hold}, 32'd0);
      check_output("rst_mi", {31'd0, mem_mi}, 32'd0);
      check_output("rst_count", {23'd0, word_count}, 32'd0);
      step();
      reset = 1'b0;
      step();

      foreach (vecs[i]) apply_stimulus(vecs[i]);

      // abort on the second word; start also races an abort in IDLE and must win
      start = 1'b1; abort = 1'b1; start_addr = 8'd200;
      @(negedge clk);
      step();
      start = 1'b0; abort = 1'b0; in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b0;
      exp_q.push_back('{a: 8'd200, d: 8'hAA});
      @(negedge clk);
      check_output("abort_start_wins", {31'd0, mem_mi}, 32'd1);
      step();
      @(negedge clk);
      check_output("abort_first_ri", {31'd0, mem_ri}, 32'd1);
      step();
      in_data = 8'hBB;
      @(negedge clk);
      step();
      abort = 1'b1;
      @(negedge clk);
      check_output("abort_ready", {31'd0, in_ready}, 32'd0);
      check_output("abort_ri", {31'd0, mem_ri}, 32'd0);
      step();
      abort = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check_output("abort_park_mi", {31'd0, mem_mi}, 32'd1);
      check_output("abort_park_bus", {24'd0, mem_write}, 32'd0);
      step();
      @(negedge clk);
      check_output("abort_done", {31'd0, done}, 32'd1);
      check_output("abort_count", {23'd0, word_count}, 32'd1);
      check_output("abort_ovf", {31'd0, overflow}, 32'd0);
      step();
      @(negedge clk);
      check_output("abort_ram0", {24'd0, ram[200]}, 32'hAA);
      check_output("abort_ram1", {24'd0, ram[201]}, 32'h00);
      check_output("abort_sb", exp_q.size(), 0);
      step();

      // reset while in DATA with a valid word on the bus
      start = 1'b1; start_addr = 8'd30;
      @(negedge clk);
      step();
      start = 1'b0;
      @(negedge clk);
      step();
      reset = 1'b1; in_valid = 1'b1; in_data = 8'h77;
      @(negedge clk);
      check_output("mid_rst_ri", {31'd0, mem_ri}, 32'd0);
      check_output("mid_rst_ready", {31'd0, in_ready}, 32'd0);
      check_output("mid_rst_mi", {31'd0, mem_mi}, 32'd0);
      check_output("mid_rst_bus", {24'd0, mem_write}, 32'd0);
      check_output("mid_rst_hold", {31'd0, cpu_hold}, 32'd0);
      check_output("mid_rst_busy", {31'd0, busy}, 32'd0);
      check_output("mid_rst_count", {23'd0, word_count}, 32'd0);
      step();
      reset = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check_output("post_rst_idle", {31'd0, busy}, 32'd0);
      step();
      apply_stimulus(vecs[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
